// File: rtl/life_grid_engine_if.sv
// Control, seeding and read-port bundle of the row-serial Game-of-Life engine.
// The master drives the requests and the seed/read addresses; the slave returns status and cell data.
interface life_grid_engine_if #(
  parameter int COLS  = 64,
  parameter int ROWS  = 48,
  parameter int GEN_W = 16,
  parameter int POP_W = 12
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             seed_en;
  logic [RW-1:0]    seed_row;
  logic [COLS-1:0]  seed_data;
  logic             step;
  logic             run;
  logic             tick;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic             rd_data;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic [POP_W-1:0] pop_count;
  logic             stable;

  modport master (
    output seed_en, seed_row, seed_data, step, run, tick, rd_row, rd_col,
    input  rd_data, busy, done, gen_count, pop_count, stable
  );

  modport slave (
    input  seed_en, seed_row, seed_data, step, run, tick, rd_row, rd_col,
    output rd_data, busy, done, gen_count, pop_count, stable
  );
endinterface

// File: rtl/life_grid_engine.sv
// Row-serial Game-of-Life engine: one grid row is updated per clock, so a generation takes ROWS cycles.
// It provides optional toroidal edges, step/run control, row seeding, generation/population counts and still-life detection.
module life_grid_engine #(
  parameter int COLS  = 64,
  parameter int ROWS  = 48,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16,
  parameter int POP_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  life_grid_engine_if.slave  bus
);
  localparam int RW      = $clog2(ROWS);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state, w_state_next;
  logic [COLS-1:0]  r_grid [ROWS];
  logic [COLS-1:0]  r_prev;
  logic [COLS-1:0]  r_row0;
  logic [RW-1:0]    r_row;
  logic [POP_W-1:0] r_pop_acc;
  logic [POP_W-1:0] r_pop;
  logic [GEN_W-1:0] r_gen;
  logic             r_changed;
  logic             r_done;
  logic             r_stable;
  logic             r_rd_data;

  logic             w_start;
  logic             w_seed_wr;
  logic             w_begin;
  logic             w_last;
  logic [RW-1:0]    w_row_p1;
  logic [COLS-1:0]  w_above, w_cur, w_below, w_new_row;
  logic [COLS+1:0]  w_ext_a, w_ext_c, w_ext_b;
  logic [3:0]       w_sum;
  logic [POP_W-1:0] w_row_pop;
  logic             w_row_changed;

  // Pads a row with one ghost cell on each side: column -1 in bit 0 and column COLS in the MSB.
  function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] row);
    return {WRAP_EN & row[0], row, WRAP_EN & row[COLS-1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case; otherwise a missed path would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_seed_wr    = 1'b0;
    w_begin      = 1'b0;
    w_last       = 1'b0;
    w_start      = bus.step | (bus.run & bus.tick);
    case (r_state)
      S_IDLE: begin
        if (bus.seed_en) begin
          w_seed_wr = 1'b1;
        end else if (w_start) begin
          w_begin      = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (r_row == RW'(ROWS - 1)) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row r-1 was overwritten in the previous cycle, so its old value comes from r_prev. Row 0 was saved on entry.
  assign w_row_p1 = r_row + RW'(1);
  assign w_cur    = r_grid[r_row];
  assign w_above  = (r_row == '0) ? (WRAP_EN ? r_grid[ROWS-1] : '0) : r_prev;
  assign w_below  = (r_row == RW'(ROWS - 1)) ? (WRAP_EN ? r_row0 : '0) : r_grid[w_row_p1];
  assign w_ext_a  = extend(w_above);
  assign w_ext_c  = extend(w_cur);
  assign w_ext_b  = extend(w_below);

  always_comb begin
    w_new_row = '0;
    w_row_pop = '0;
    w_sum     = '0;
    for (int c = 0; c < COLS; c++) begin
      w_sum = 4'(w_ext_a[c]) + 4'(w_ext_a[c+1]) + 4'(w_ext_a[c+2])
            + 4'(w_ext_c[c])                    + 4'(w_ext_c[c+2])
            + 4'(w_ext_b[c]) + 4'(w_ext_b[c+1]) + 4'(w_ext_b[c+2]);
      w_new_row[c] = (w_sum == 4'd3) | (w_ext_c[c+1] & (w_sum == 4'd2));
      w_row_pop    = w_row_pop + POP_W'(w_new_row[c]);
    end
  end

  assign w_row_changed = (w_new_row != w_cur);

  // NOTE: the cell array is built from flops with a synchronous clear, because reset must kill every cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) r_grid[i] <= '0;
      r_prev    <= '0;
      r_row0    <= '0;
      r_row     <= '0;
      r_pop_acc <= '0;
      r_pop     <= '0;
      r_gen     <= '0;
      r_changed <= 1'b0;
      r_done    <= 1'b0;
      r_stable  <= 1'b0;
      r_rd_data <= 1'b0;
    end else begin
      r_done    <= w_last;
      r_rd_data <= (int'(bus.rd_row) < ROWS && int'(bus.rd_col) < COLS)
                   ? r_grid[bus.rd_row][bus.rd_col] : 1'b0;
      if (w_seed_wr && int'(bus.seed_row) < ROWS)
        r_grid[bus.seed_row] <= bus.seed_data;
      if (w_begin) begin
        r_row     <= '0;
        r_row0    <= r_grid[0];
        r_pop_acc <= '0;
        r_changed <= 1'b0;
      end
      if (r_state == S_CALC) begin
        r_grid[r_row] <= w_new_row;
        r_prev        <= w_cur;
        r_row         <= w_row_p1;
        r_pop_acc     <= r_pop_acc + w_row_pop;
        r_changed     <= r_changed | w_row_changed;
        if (w_last) begin
          r_gen    <= r_gen + GEN_W'(1);
          r_pop    <= r_pop_acc + w_row_pop;
          r_stable <= ~(r_changed | w_row_changed);
        end
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.busy      = (r_state == S_CALC);
  assign bus.done      = r_done;
  assign bus.gen_count = r_gen;
  assign bus.pop_count = r_pop;
  assign bus.stable    = r_stable;
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: a dead-edge instance and a toroidal instance run side by side.
// The expected patterns are hand-derived and are compared through the registered read port.
module tb_life_grid_engine;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   done_cnt;
  int   done_cyc [$];
  bit   exp_g [48][64];

  life_grid_engine_if #(.COLS(64), .ROWS(48), .GEN_W(16), .POP_W(12)) if0 ();
  life_grid_engine_if #(.COLS(64), .ROWS(48), .GEN_W(16), .POP_W(12)) if1 ();

  life_grid_engine #(.COLS(64), .ROWS(48), .WRAP(0), .GEN_W(16), .POP_W(12)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  life_grid_engine #(.COLS(64), .ROWS(48), .WRAP(1), .GEN_W(16), .POP_W(12)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (if0.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic seed(input bit [1:0] m, input int row, input logic [63:0] data);
    @(negedge clk);
    if (m[0]) begin if0.seed_en = 1'b1; if0.seed_row = 6'(row); if0.seed_data = data; end
    if (m[1]) begin if1.seed_en = 1'b1; if1.seed_row = 6'(row); if1.seed_data = data; end
    @(negedge clk);
    if0.seed_en = 1'b0;
    if1.seed_en = 1'b0;
  endtask

  // Pulses step and counts clock edges from the one that samples it up to the first visible done.
  task automatic gen(input bit [1:0] m, output int lat);
    @(negedge clk);
    if (m[0]) if0.step = 1'b1;
    if (m[1]) if1.step = 1'b1;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if0.step = 1'b0;
      if1.step = 1'b0;
      if (((m[0] ? if0.done : if1.done)) === 1'b1) break;
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 48; r++)
      for (int c = 0; c < 64; c++) exp_g[r][c] = 1'b0;
  endtask

  task automatic set_exp_row(input int r, input logic [63:0] data);
    for (int c = 0; c < 64; c++) exp_g[r][c] = data[c];
  endtask

  task automatic check_grid(input int sel, input string tag);
    int   mism;
    logic obs;
    mism = 0;
    for (int r = 0; r < 48; r++) begin
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if0.rd_row = 6'(r); if0.rd_col = 6'(c);
        if1.rd_row = 6'(r); if1.rd_col = 6'(c);
        @(posedge clk);
        #1;
        obs = (sel == 1) ? if1.rd_data : if0.rd_data;
        if (obs !== exp_g[r][c]) begin
          if (mism == 0) $display("first bad cell in %s at (%0d,%0d): got %b", tag, r, c, obs);
          mism++;
        end
      end
    end
    check(tag, mism, 0);
  endtask

  initial begin
    int lat;
    int snap;
    vectors = 0; miscompares = 0; cyc = 0; done_cnt = 0;
    reset = 1'b1;
    if0.seed_en = 0; if0.seed_row = '0; if0.seed_data = '0; if0.step = 0; if0.run = 0; if0.tick = 0;
    if0.rd_row = '0; if0.rd_col = '0;
    if1.seed_en = 0; if1.seed_row = '0; if1.seed_data = '0; if1.step = 0; if1.run = 0; if1.tick = 0;
    if1.rd_row = '0; if1.rd_col = '0;

    // Reset state
    do_reset();
    check("rst_gen", 32'(if0.gen_count), 0);
    check("rst_pop", 32'(if0.pop_count), 0);
    check("rst_busy", 32'(if0.busy), 0);
    check("rst_done", 32'(if0.done), 0);
    check("rst_stable", 32'(if0.stable), 0);
    clear_exp();
    check_grid(0, "rst_grid0");
    check_grid(1, "rst_grid1");

    // Blinker, dead edges: horizontal -> vertical -> horizontal
    seed(2'b01, 10, 64'(7) << 20);
    gen(2'b01, lat);
    check("blink_latency", lat, 49);
    check("blink1_pop", 32'(if0.pop_count), 3);
    check("blink1_gen", 32'(if0.gen_count), 1);
    check("blink1_stable", 32'(if0.stable), 0);
    check("blink1_busy", 32'(if0.busy), 0);
    clear_exp();
    exp_g[9][21] = 1; exp_g[10][21] = 1; exp_g[11][21] = 1;
    check_grid(0, "blink1_grid");
    gen(2'b01, lat);
    check("blink2_gen", 32'(if0.gen_count), 2);
    check("blink2_pop", 32'(if0.pop_count), 3);
    clear_exp();
    set_exp_row(10, 64'(7) << 20);
    check_grid(0, "blink2_grid");

    // 2x2 block still life
    do_reset();
    seed(2'b01, 5, 64'h60);
    seed(2'b01, 6, 64'h60);
    gen(2'b01, lat);
    check("block_pop", 32'(if0.pop_count), 4);
    check("block_stable", 32'(if0.stable), 1);
    check("block_gen", 32'(if0.gen_count), 1);
    clear_exp();
    set_exp_row(5, 64'h60);
    set_exp_row(6, 64'h60);
    check_grid(0, "block_grid");

    // Corner row on both edge modes
    do_reset();
    seed(2'b11, 0, 64'h7);
    gen(2'b11, lat);
    check("corner_lat", lat, 49);
    check("corner_pop_nowrap", 32'(if0.pop_count), 2);
    check("corner_pop_wrap", 32'(if1.pop_count), 3);
    check("corner_stable_wrap", 32'(if1.stable), 0);
    clear_exp();
    exp_g[0][1] = 1; exp_g[1][1] = 1;
    check_grid(0, "corner_grid_nowrap");
    exp_g[47][1] = 1;
    check_grid(1, "corner_grid_wrap");

    // Free run: five ticks 100 cycles apart, with a step dropped while busy
    do_reset();
    seed(2'b01, 10, 64'(7) << 20);
    done_cyc.delete();
    snap = done_cnt;
    @(negedge clk);
    if0.run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); if0.tick = 1'b1;
      @(negedge clk); if0.tick = 1'b0;
      if (k == 1) begin
        repeat (10) @(negedge clk);
        check("run_busy_mid", 32'(if0.busy), 1);
        if0.step = 1'b1;
        @(negedge clk); if0.step = 1'b0;
        repeat (87) @(negedge clk);
      end else begin
        repeat (98) @(negedge clk);
      end
    end
    if0.run = 1'b0;
    repeat (20) @(negedge clk);
    check("run_gen", 32'(if0.gen_count), 5);
    check("run_done_cnt", 32'(done_cnt - snap), 5);
    for (int i = 0; i + 1 < done_cyc.size(); i++)
      check("run_done_spacing", 32'(done_cyc[i+1] - done_cyc[i]), 100);
    check("run_pop", 32'(if0.pop_count), 3);

    // Reset in the middle of a generation
    @(negedge clk);
    if0.rd_row = 6'd10; if0.rd_col = 6'd21;
    @(negedge clk);
    check("pre_rst_rd", 32'(if0.rd_data), 1);
    if0.step = 1'b1;
    @(negedge clk); if0.step = 1'b0;
    repeat (20) @(negedge clk);
    check("midcalc_busy", 32'(if0.busy), 1);
    snap = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(if0.busy), 0);
    check("midrst_done", 32'(if0.done), 0);
    check("midrst_gen", 32'(if0.gen_count), 0);
    check("midrst_pop", 32'(if0.pop_count), 0);
    check("midrst_stable", 32'(if0.stable), 0);
    check("midrst_rd", 32'(if0.rd_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - snap), 0);
    clear_exp();
    check_grid(0, "midrst_grid");

    // seed_en wins over step in the same idle cycle
    snap = done_cnt;
    @(negedge clk);
    if0.seed_en = 1'b1; if0.seed_row = 6'd3; if0.seed_data = 64'h8000_0000_0000_0001;
    if0.step = 1'b1;
    @(negedge clk);
    if0.seed_en = 1'b0; if0.step = 1'b0;
    check("seedstep_busy", 32'(if0.busy), 0);
    repeat (60) @(negedge clk);
    check("seedstep_gen", 32'(if0.gen_count), 0);
    check("seedstep_no_done", 32'(done_cnt - snap), 0);
    clear_exp();
    set_exp_row(3, 64'h8000_0000_0000_0001);
    check_grid(0, "seedstep_grid");
    @(negedge clk);
    if0.rd_row = 6'd50; if0.rd_col = 6'd0;
    @(negedge clk);
    check("rd_out_of_range", 32'(if0.rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Game-of-Life core that replaces the fixed 64x48 single-cycle update with a row-serial engine: one grid row is computed per clock.
- Adds configurable grid size, an optional toroidal (wrap) edge mode, single-step and free-run control, a row seeding port, a generation counter, a population count and still-life detection.
- Sits between the board controls (buttons, switches, divided tick) and the VGA pixel path, which reads cells through a registered read port.

Parameters:
- COLS, 64: grid width in cells; ≥3.
- ROWS, 48: grid height in cells; ≥3.
- WRAP, 0: 0 = dead boundary (off-grid neighbours read 0); 1 = toroidal (indices taken modulo COLS/ROWS).
- GEN_W, 16: generation counter width.
- POP_W, 12: population counter width; must satisfy 2^POP_W > ROWS*COLS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seed_en  in  1  write seed_data into row seed_row (accepted only in IDLE).
- seed_row  in  clog2(ROWS)  target row for seeding.
- seed_data  in  COLS  row contents; bit c = column c.
- step  in  1  one-cycle pulse requesting exactly one generation.
- run  in  1  level; while high, each tick pulse requests one generation.
- tick  in  1  one-cycle generation-rate strobe (divided clock, made synchronous).
- rd_row  in  clog2(ROWS)  read row address.
- rd_col  in  clog2(COLS)  read column address.
- rd_data  out  1  cell at (rd_row, rd_col); 1-cycle latency.
- busy  out  1  high while a generation is being computed.
- done  out  1  one-cycle pulse when a generation completes.
- gen_count  out  GEN_W  completed generations since reset.
- pop_count  out  POP_W  live cells in the last completed generation (or 0).
- stable  out  1  last generation equal to its predecessor.

Behaviour:
- Reset, synchronous and dominant in every state:
  - all cells 0; state IDLE.
  - busy=0, done=0, gen_count=0, pop_count=0, stable=0, rd_data=0.
  - A reset during CALC aborts the generation; no done pulse is produced.
- IDLE: priority seed_en > start, where start = step | (run & tick).
  - seed_en writes the whole row at seed_row; a start in the same cycle is dropped.
  - Otherwise, start moves the block to CALC with row index r=0.
  - seed_en while busy is ignored. step or tick while busy is dropped; requests are not queued.
- CALC: lasts exactly ROWS cycles (r = 0..ROWS-1). In each cycle, row r's new value is written into the array.
  - The old row r-1 is held in a "previous" register, because it has already been overwritten.
  - The old row r and old row r+1 are read from the array.
  - The old row 0 is saved on entry. If WRAP=1, it is used as row r+1 when r=ROWS-1.
  - If WRAP=1, the saved row ROWS-1 equivalent is used as row r-1 when r=0, i.e. the array value, which is not yet overwritten.
- Rule: a live cell survives with 2 or 3 live neighbours; a dead cell is born with exactly 3; every other cell becomes 0. Neighbour sum is 0..8, computed at 4-bit width.
- Boundary: with WRAP=0, neighbours at row -1/ROWS and column -1/COLS are 0. With WRAP=1, column -1 maps to COLS-1 and column COLS maps to 0; rows wrap the same way.
- Per row, the popcount of the new row is accumulated and a row-changed flag is ORed.
- Completion: in the cycle after the last row, the block returns to IDLE and:
  - done=1 for one cycle and busy=0.
  - gen_count increments, wrapping modulo 2^GEN_W.
  - pop_count is loaded with the accumulated total.
  - stable = no row changed.
  - Total latency from the accepted start to done is ROWS+1 cycles.
- Seeding does not change gen_count, pop_count or stable.
- Read port: rd_data is registered from the array each cycle in every state. During CALC it can return a mix of old and new rows (tear is accepted for display). Out-of-range addresses return 0.

Test Plan:
- Apply reset, then read all cells → every rd_data=0; gen_count=0, pop_count=0, busy=0.
- WRAP=0: seed row 10 with columns 20..22 set, then pulse step → done exactly 49 cycles later. Cells (9,21), (10,21), (11,21) are 1 and all others 0; pop_count=3, gen_count=1, stable=0. A second step restores the horizontal row.
- 2x2 block at rows 5..6, columns 5..6, then step → grid unchanged, pop_count=4, stable=1.
- Row 0 with columns 0..2 set, then step:
  - WRAP=0 → cells (0,1), (1,1); pop_count=2.
  - WRAP=1 → cells (47,1), (0,1), (1,1); pop_count=3.
- run=1 with tick every 100 cycles for 5 ticks → gen_count=5, done pulses spaced 100 cycles apart. A step pulsed mid-CALC does not add a generation. Reset asserted mid-CALC → all outputs 0 on the next cycle and no done pulse.
- seed_en and step in the same IDLE cycle → row written, busy stays 0, gen_count unchanged.
